// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed scanner for a multi-digit BCD display.  Only one digit
//   code is presented at a time, to a downstream seven-segment decoder.
//   The value to show is offered with a one-cycle load strobe.  A load is
//   rejected if any nibble is above 9; a rejected load raises a one-cycle
//   err pulse.  An accepted load is parked in a shadow register.  That value
//   is copied into the display register only at the end of a scan frame, so
//   the display never shows a mix of old and new digits.  Leading zeros can
//   be blanked; digit 0 is never blanked.
//
// Parameters
//   DIGITS   number of BCD digits scanned (>= 2)
//   DIV      clock cycles each digit is held (>= 1)
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   asynchronous active-high reset
//   load      in   one-cycle strobe offering din
//   din       in   BCD value, nibble 0 is the least significant digit
//   blank_lz  in   level, enables leading-zero blanking (not registered)
//   s         out  digit code for the decoder, always 0..9
//   an        out  one-hot digit enable, bit i selects digit i
//   blank     out  current digit is to be dark
//   err       out  one-cycle pulse after a rejected load
//   frame     out  one-cycle pulse on the first cycle of each scan frame
// -----------------------------------------------------------------------------
module seg_scan_driver #(
   parameter int DIGITS = 4,
   parameter int DIV    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [4*DIGITS-1:0] din,
   input  logic                blank_lz,
   output logic [3:0]          s,
   output logic [DIGITS-1:0]   an,
   output logic                blank,
   output logic                err,
   output logic                frame
);

   localparam int W     = 4 * DIGITS;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = $clog2(DIGITS);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   // True when every nibble of v is a legal BCD digit.
   function automatic logic bcd_valid(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     shd_q, shd_d;
   logic [W-1:0]     dsp_q, dsp_d;
   logic             err_q, err_d;
   logic             frame_q, frame_d;

   logic tick;
   logic wrap;
   logic load_ok;

   always_comb begin
      tick    = (cnt_q == CNT_LAST);
      wrap    = tick && (idx_q == IDX_LAST);
      load_ok = load && bcd_valid(din);

      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

      idx_d = idx_q;
      if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

      shd_d = load_ok ? din : shd_q;
      // shd_d already folds in a valid load landing on the wrap cycle, so
      // that load goes straight to the display without a frame of delay.
      dsp_d = wrap ? shd_d : dsp_q;

      err_d   = load && !load_ok;
      frame_d = wrap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         shd_q   <= '0;
         dsp_q   <= '0;
         err_q   <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shd_q   <= shd_d;
         dsp_q   <= dsp_d;
         err_q   <= err_d;
         frame_q <= frame_d;
      end
   end

   // Digit outputs are decoded straight from the registered scan position.
   always_comb begin
      logic rest_zero;
      rest_zero = 1'b1;
      // A digit is a leading zero when it and every more significant digit
      // are zero.
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= int'(idx_q) && dsp_q[4*i +: 4] != 4'd0) rest_zero = 1'b0;
      end
      s     = dsp_q[4*idx_q +: 4];
      an    = DIGITS'(1) << idx_q;
      blank = blank_lz && (idx_q != '0) && rest_zero;
   end

   assign err   = err_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//   Self-checking bench for seg_scan_driver.  The reference model counts
//   cycles since reset release.  It derives the scan position from that
//   count and remembers the last valid load.  That load becomes the
//   displayed value at every frame boundary.  A second instance with DIV=1
//   covers fast rotation and the asynchronous mid-frame reset.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

   localparam int DIGITS = 4;
   localparam int DIV    = 4;
   localparam int F      = DIGITS * DIV;
   localparam int W      = 4 * DIGITS;
   localparam int VW     = 4 + DIGITS + 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (DIV=4)
   logic              rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
   logic [W-1:0]      din = '0;
   logic [3:0]        s;
   logic [DIGITS-1:0] an;
   logic              blank, err, frame;

   // fast instance (DIV=1)
   logic              rst1 = 1'b1, load1 = 1'b0, blz1 = 1'b0;
   logic [W-1:0]      din1 = '0;
   logic [3:0]        s1;
   logic [DIGITS-1:0] an1;
   logic              blank1, err1, frame1;

   seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
      .clk(clk), .rst(rst), .load(load), .din(din), .blank_lz(blank_lz),
      .s(s), .an(an), .blank(blank), .err(err), .frame(frame));

   seg_scan_driver #(.DIGITS(DIGITS), .DIV(1)) dut1 (
      .clk(clk), .rst(rst1), .load(load1), .din(din1), .blank_lz(blz1),
      .s(s1), .an(an1), .blank(blank1), .err(err1), .frame(frame1));

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int           t;
   logic [W-1:0] pend, shown;
   logic         exp_err, exp_frame;

   wire [VW-1:0] obs = {s, an, blank, err, frame};

   function automatic bit bcd_ok(input logic [W-1:0] v);
      for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [VW-1:0] expv();
      int                idx;
      logic [3:0]        es;
      logic [DIGITS-1:0] ean;
      logic              eb;
      idx = (t / DIV) % DIGITS;
      es  = shown[4*idx +: 4];
      ean = DIGITS'(1) << idx;
      eb  = blank_lz && (idx != 0) && ((shown >> (4*idx)) == '0);
      return {es, ean, eb, exp_err, exp_frame};
   endfunction

   function automatic logic [W-1:0] rand_din();
      logic [W-1:0] v;
      int k;
      for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) begin
         k = $urandom_range(0, DIGITS - 1);
         v[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      return v;
   endfunction

   task automatic model_reset();
      t = 0; pend = '0; shown = '0; exp_err = 1'b0; exp_frame = 1'b0;
   endtask

   // Advance one clock; the model consumes the inputs seen at that edge.
   task automatic step();
      @(posedge clk);
      if (load) begin
         if (bcd_ok(din)) pend = din;
         exp_err = !bcd_ok(din);
      end else begin
         exp_err = 1'b0;
      end
      t++;
      exp_frame = (t % F == 0);
      if (exp_frame) shown = pend;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; din = '0; blank_lz = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (obs !== expv()) begin
         n_fail++;
         $display("FAIL reset_async got %h want %h", obs, expv());
      end
      @(posedge clk); #1;
      n_tests++;
      if (obs !== expv()) begin
         n_fail++;
         $display("FAIL reset_hold got %h want %h", obs, expv());
      end
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         n_tests++;
         if (obs !== expv()) begin
            n_fail++;
            $display("FAIL reset_scan t=%0d got %h want %h", t, obs, expv());
         end
         step();
      end
   endtask

   task automatic test_load_basic();
      bit done = 0;
      for (int c = 0; c < 3*F; c++) begin
         load = (!done && t % F == 8);
         din  = 16'h1234;
         if (load) done = 1;
         #1;
         n_tests++;
         if (obs !== expv()) begin
            n_fail++;
            $display("FAIL load_basic t=%0d got %h want %h", t, obs, expv());
         end
         step();
      end
      load = 1'b0;
   endtask

   task automatic test_blanking();
      bit a = 0, b = 0;
      blank_lz = 1'b1;
      for (int c = 0; c < 5*F; c++) begin
         load = 1'b0;
         if (!a && t % F == 3) begin load = 1'b1; din = 16'h0070; a = 1; end
         else if (a && !b && shown == 16'h0070 && t % F == 3) begin
            load = 1'b1; din = 16'h0000; b = 1;
         end
         #1;
         n_tests++;
         if (obs !== expv()) begin
            n_fail++;
            $display("FAIL blanking t=%0d got %h want %h", t, obs, expv());
         end
         step();
      end
      load = 1'b0; blank_lz = 1'b0;
   endtask

   task automatic test_invalid_load();
      bit a = 0, b = 0;
      int err_seen = 0;
      for (int c = 0; c < 5*F; c++) begin
         load = 1'b0;
         if (!a && t % F == 1) begin load = 1'b1; din = 16'h5678; a = 1; end
         else if (a && !b && shown == 16'h5678 && t % F == 5) begin
            load = 1'b1; din = 16'h12A4; b = 1;
         end
         #1;
         if (err) err_seen++;
         n_tests++;
         if (obs !== expv()) begin
            n_fail++;
            $display("FAIL invalid_load t=%0d got %h want %h", t, obs, expv());
         end
         step();
      end
      load = 1'b0;
      n_tests++;
      if (err_seen !== 1) begin
         n_fail++;
         $display("FAIL invalid_err_count got %0d want 1", err_seen);
      end
   endtask

   task automatic test_wrap_load();
      bit a = 0, b = 0, d = 0;
      for (int c = 0; c < 6*F; c++) begin
         load = 1'b0;
         if (!a && t % F == F - 1) begin load = 1'b1; din = 16'h9999; a = 1; end
         else if (a && !b && shown == 16'h9999 && t % F == 2) begin
            load = 1'b1; din = 16'h1111; b = 1;
         end else if (b && !d && t % F == 9) begin
            load = 1'b1; din = 16'h2222; d = 1;
         end
         #1;
         n_tests++;
         if (obs !== expv()) begin
            n_fail++;
            $display("FAIL wrap_load t=%0d got %h want %h", t, obs, expv());
         end
         step();
      end
      load = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         load = ($urandom_range(0, 5) == 0);
         din  = rand_din();
         if ($urandom_range(0, 9) == 0) blank_lz = ~blank_lz;
         #1;
         n_tests++;
         if (obs !== expv()) begin
            n_fail++;
            $display("FAIL random t=%0d got %h want %h", t, obs, expv());
         end
         step();
      end
      load = 1'b0;
   endtask

   // Park a value in the shadow register, then reset on a cycle where err
   // and frame are both high; everything must clear with no clock edge.
   task automatic test_midframe_reset();
      bit a = 0, b = 0, d = 0;
      for (int c = 0; c < 4*F && !d; c++) begin
         load = 1'b0;
         if (!a && t % F == 5) begin load = 1'b1; din = 16'h7777; a = 1; end
         else if (a && !b && shown == 16'h7777 && t % F == 6) begin
            load = 1'b1; din = 16'h4321; b = 1;
         end else if (b && t % F == F - 1) begin
            load = 1'b1; din = 16'hABCD; d = 1;
         end
         #1;
         n_tests++;
         if (obs !== expv()) begin
            n_fail++;
            $display("FAIL pre_reset t=%0d got %h want %h", t, obs, expv());
         end
         step();
      end
      load = 1'b0;
      #1;
      n_tests++;
      if (obs !== expv()) begin
         n_fail++;
         $display("FAIL pre_reset_pulse t=%0d got %h want %h", t, obs, expv());
      end
      rst = 1'b1;
      model_reset();
      #1;
      n_tests++;
      if (obs !== expv()) begin
         n_fail++;
         $display("FAIL midframe_reset got %h want %h", obs, expv());
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 2*F + 3; c++) begin
         #1;
         n_tests++;
         if (obs !== expv()) begin
            n_fail++;
            $display("FAIL post_reset t=%0d got %h want %h", t, obs, expv());
         end
         step();
      end
   endtask

   task automatic test_div1();
      logic [3:0]        es;
      logic [DIGITS-1:0] ean;
      rst1 = 1'b1; load1 = 1'b0; din1 = '0; blz1 = 1'b0;
      @(posedge clk); #1;
      rst1 = 1'b0;
      for (int c = 0; c <= 12; c++) begin
         load1 = (c == 5 || c == 11);
         din1  = (c == 5) ? 16'h9999 : 16'hF000;
         #1;
         es  = (c >= 8) ? 4'd9 : 4'd0;
         ean = DIGITS'(1) << (c % DIGITS);
         n_tests++;
         if ({s1, an1, blank1, err1, frame1} !==
             {es, ean, 1'b0, (c == 12), (c > 0 && c % DIGITS == 0)}) begin
            n_fail++;
            $display("FAIL div1_scan c=%0d got %h want %h", c,
                     {s1, an1, blank1, err1, frame1},
                     {es, ean, 1'b0, (c == 12), (c > 0 && c % DIGITS == 0)});
         end
         if (c < 12) begin @(posedge clk); #1; end
      end
      load1 = 1'b0;
      rst1  = 1'b1;
      #1;
      n_tests++;
      if ({s1, an1, blank1, err1, frame1} !== {4'd0, 4'b0001, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL div1_async_reset got %h want %h",
                  {s1, an1, blank1, err1, frame1}, {4'd0, 4'b0001, 3'b000});
      end
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_blanking();
      test_invalid_load();
      test_wrap_load();
      test_random();
      test_midframe_reset();
      test_div1();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
